// File: rtl/dit_butterfly_pe.sv
// dit_butterfly_pe: three-stage pipelined radix-2 DIT butterfly, t = W*b, y0 = a + t, y1 = a - t.
// Define DIT_BF_SCALE_EN to halve every output (block-floating growth control); by default outputs wrap unscaled.
module dit_butterfly_pe #(
    parameter int DW      = 16,
    parameter int TW_FRAC = 14,
    parameter int TAG_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    a_re_i,
    input  logic [DW-1:0]    a_im_i,
    input  logic [DW-1:0]    b_re_i,
    input  logic [DW-1:0]    b_im_i,
    input  logic [DW-1:0]    tw_re_i,
    input  logic [DW-1:0]    tw_im_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    y0_re_o,
    output logic [DW-1:0]    y0_im_o,
    output logic [DW-1:0]    y1_re_o,
    output logic [DW-1:0]    y1_im_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i
);

    logic             en1, en2, en3;
    logic             v1_q, v2_q, v3_q;
    logic [DW-1:0]    a_re1_q, a_im1_q, b_re1_q, b_im1_q, tw_re1_q, tw_im1_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [2*DW-1:0]  prr_d, pii_d, pri_d, pir_d;
    logic [2*DW-1:0]  prr_q, pii_q, pri_q, pir_q;
    logic [DW-1:0]    a_re2_q, a_im2_q;
    logic [2*DW:0]    p_re, p_im;
    logic [DW+1:0]    t_re, t_im, a_re_x, a_im_x;
    logic [DW+1:0]    s_d [4];
    logic [DW+1:0]    r_d [4];
    logic [DW-1:0]    y_q [4];
    logic             ovf_hit, ovf_d, ovf_q;
    logic             unused_bits;

    function automatic logic [2*DW-1:0] smul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        return $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{y[DW-1]}}, y});
    endfunction

    // Backpressure ripples combinationally from the output, so a full pipeline streams without bubbles.
    assign en3        = ~v3_q | out_ready_i;
    assign en2        = ~v2_q | en3;
    assign en1        = ~v1_q | en2;
    assign in_ready_o = en1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q     <= 1'b0;
            a_re1_q  <= '0;
            a_im1_q  <= '0;
            b_re1_q  <= '0;
            b_im1_q  <= '0;
            tw_re1_q <= '0;
            tw_im1_q <= '0;
            tag1_q   <= '0;
        end else if (en1) begin
            v1_q     <= in_valid_i;
            a_re1_q  <= a_re_i;
            a_im1_q  <= a_im_i;
            b_re1_q  <= b_re_i;
            b_im1_q  <= b_im_i;
            tw_re1_q <= tw_re_i;
            tw_im1_q <= tw_im_i;
            tag1_q   <= in_tag_i;
        end
    end

    assign prr_d = smul(b_re1_q, tw_re1_q);
    assign pii_d = smul(b_im1_q, tw_im1_q);
    assign pri_d = smul(b_re1_q, tw_im1_q);
    assign pir_d = smul(b_im1_q, tw_re1_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2_q    <= 1'b0;
            prr_q   <= '0;
            pii_q   <= '0;
            pri_q   <= '0;
            pir_q   <= '0;
            a_re2_q <= '0;
            a_im2_q <= '0;
            tag2_q  <= '0;
        end else if (en2) begin
            v2_q    <= v1_q;
            prr_q   <= prr_d;
            pii_q   <= pii_d;
            pri_q   <= pri_d;
            pir_q   <= pir_d;
            a_re2_q <= a_re1_q;
            a_im2_q <= a_im1_q;
            tag2_q  <= tag1_q;
        end
    end

    // Taking bits [TW_FRAC+DW+1:TW_FRAC] is the floor shift by TW_FRAC already truncated to DW+2 bits.
    assign p_re   = {prr_q[2*DW-1], prr_q} - {pii_q[2*DW-1], pii_q};
    assign p_im   = {pri_q[2*DW-1], pri_q} + {pir_q[2*DW-1], pir_q};
    assign t_re   = p_re[TW_FRAC+DW+1:TW_FRAC];
    assign t_im   = p_im[TW_FRAC+DW+1:TW_FRAC];
    assign a_re_x = {{2{a_re2_q[DW-1]}}, a_re2_q};
    assign a_im_x = {{2{a_im2_q[DW-1]}}, a_im2_q};

    always_comb begin
        ovf_hit = 1'b0;
        s_d[0]  = a_re_x + t_re;
        s_d[1]  = a_im_x + t_im;
        s_d[2]  = a_re_x - t_re;
        s_d[3]  = a_im_x - t_im;
        for (int k = 0; k < 4; k++) begin
`ifdef DIT_BF_SCALE_EN
            r_d[k] = {s_d[k][DW+1], s_d[k][DW+1:1]};
`else
            r_d[k] = s_d[k];
`endif
            ovf_hit = ovf_hit | ((r_d[k][DW+1:DW-1] != '0) && (r_d[k][DW+1:DW-1] != '1));
        end
    end

    // Only a real beat entering S3 may raise the flag; a simultaneous clear loses to the set.
    assign ovf_d       = (ovf_hit & v2_q & en3) | (ovf_q & ~ovf_clr_i);
    assign unused_bits = ^{p_re, p_im, s_d[0], s_d[1], s_d[2], s_d[3]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v3_q   <= 1'b0;
            tag3_q <= '0;
            ovf_q  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            if (en3) begin
                v3_q   <= v2_q;
                tag3_q <= tag2_q;
                for (int k = 0; k < 4; k++) begin
                    y_q[k] <= r_d[k][DW-1:0];
                end
            end
        end
    end

    assign out_valid_o = v3_q;
    assign y0_re_o     = y_q[0];
    assign y0_im_o     = y_q[1];
    assign y1_re_o     = y_q[2];
    assign y1_im_o     = y_q[3];
    assign out_tag_o   = tag3_q;
    assign ovf_o       = ovf_q;

endmodule
